pe_seq_ctrl: RTL and testbench

Sequencer that drives the control and operand inputs of a chain of pe_top instances, which share one broadcast wire_connection code. It accepts a pass command (MAC pass or chain pass) plus an operand stream over a valid/ready handshake. It emits registered wire_connection codes and v_bus/h_bus/top data, then holds the PEs idle for a drain window and signals completion. It replaces hand-sequenced stimulus with a reusable controller that sits between the operand buffers and the PE column.

---
 rtl/pe_pkg.sv | 33 +++
 rtl/pe_seq_beat_cnt.sv | 31 +++
 rtl/pe_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE column sequencer: wire_connection codes,
// sequencer FSM states, default widths and a saturating counter helper.
package pe_pkg;

    // PE mode codes broadcast on wire_connection
    typedef enum logic [1:0] {
        WC_MAC   = 2'd0,
        WC_LOAD  = 2'd1,
        WC_CHAIN = 2'd2,
        WC_IDLE  = 2'd3
    } wc_e;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHAIN = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    localparam int DEF_WIDTH_DATA = 16;
    localparam int DEF_WIDTH_LEN  = 8;
    localparam int DEF_DRAIN_CYC  = 3;
    localparam int PERF_W         = 32;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pe_seq_beat_cnt.sv
// Loadable down-counter with a zero flag. Used once for the operand beat
// count and once for the drain window. The count stops at zero.
module pe_seq_beat_cnt
    import pe_pkg::*;
#(
    parameter int W = DEF_WIDTH_LEN
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority over decrement; decrement never wraps below zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for a column of pe_top instances sharing one wire_connection
// code. Takes a MAC or chain pass request plus an operand stream and emits
// registered PE codes and bus data, then a drain window and a done pulse.
//
// Handshake: an operand beat transfers on a rising clk edge where
// src_valid_i and src_ready_o are both high. src_ready_o depends only on
// the FSM state (high in MAC and CHAIN), never on src_valid_i.
//
// Optional build macro PE_SEQ_PERF_EN adds accepted-beat and stall-cycle
// counters (perf_beats_o, perf_stall_o).
module pe_seq_ctrl
    import pe_pkg::*;
#(
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int WIDTH_LEN  = DEF_WIDTH_LEN,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [WIDTH_LEN-1:0]  len_i,
    input  logic [WIDTH_DATA-1:0] weight_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    input  logic [WIDTH_DATA-1:0] src_v_i,
    input  logic [WIDTH_DATA-1:0] src_h_i,
    input  logic [WIDTH_DATA-1:0] src_top_i,
    output logic [1:0]            wire_connection_o,
    output logic [WIDTH_DATA-1:0] v_bus_data_o,
    output logic [WIDTH_DATA-1:0] h_bus_data_o,
    output logic [WIDTH_DATA-1:0] top_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2:0]            dbg_state_o
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_beats_o,
    output logic [PERF_W-1:0]     perf_stall_o
`endif
);

    // Drain counter only needs to hold DRAIN_CYC-1
    localparam int DRAIN_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

    seq_state_e            r_state;
    wc_e                   r_wire;
    logic [WIDTH_DATA-1:0] r_v;
    logic [WIDTH_DATA-1:0] r_h;
    logic [WIDTH_DATA-1:0] r_top;
    logic [WIDTH_DATA-1:0] r_weight;
    logic                  r_busy;
    logic                  r_done;

    logic w_ready;
    logic w_start_acc;
    logic w_beat_acc;
    logic w_beat_zero;
    logic w_beat_last;
    logic w_drain_zero;

    assign w_ready     = (r_state == ST_MAC) || (r_state == ST_CHAIN);
    // busy is still high during the done cycle, so a start there is dropped
    assign w_start_acc = (r_state == ST_IDLE) && start_i && !r_busy;
    assign w_beat_acc  = w_ready && src_valid_i;
    assign w_beat_last = w_beat_acc && w_beat_zero;

    // Beat counter holds (remaining beats - 1); zero marks the final beat
    pe_seq_beat_cnt #(.W(WIDTH_LEN)) u_beat_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_start_acc),
        .i_load_val (len_i - WIDTH_LEN'(1)),
        .i_dec      (w_beat_acc),
        .o_zero     (w_beat_zero)
    );

    // Drain counter is armed by the final beat and runs down in DRAIN
    pe_seq_beat_cnt #(.W(DRAIN_W)) u_drain_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_beat_last),
        .i_load_val (DRAIN_W'(DRAIN_CYC - 1)),
        .i_dec      (r_state == ST_DRAIN),
        .o_zero     (w_drain_zero)
    );

    // Pass FSM with registered PE code, bus data, busy and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wire   <= WC_IDLE;
            r_v      <= '0;
            r_h      <= '0;
            r_top    <= '0;
            r_weight <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wire <= WC_IDLE;
                    r_busy <= w_start_acc;
                    if (w_start_acc) begin
                        r_weight <= weight_i;
                        if (len_i == '0) begin
                            r_state <= ST_DONE;
                        end else if (mode_i) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_MAC;
                        end
                    end
                end
                ST_MAC: begin
                    if (src_valid_i) begin
                        r_wire <= WC_MAC;
                        r_v    <= src_v_i;
                        r_h    <= src_h_i;
                        if (w_beat_zero) begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_wire <= WC_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_wire  <= WC_LOAD;
                    r_h     <= r_weight;
                    r_state <= ST_CHAIN;
                end
                ST_CHAIN: begin
                    if (src_valid_i) begin
                        r_wire <= WC_CHAIN;
                        r_h    <= src_h_i;
                        r_top  <= src_top_i;
                        if (w_beat_zero) begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_wire <= WC_IDLE;
                    end
                end
                ST_DRAIN: begin
                    r_wire <= WC_IDLE;
                    r_top  <= '0;
                    if (w_drain_zero) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_wire  <= WC_IDLE;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic [PERF_W-1:0] r_perf_beats;
    logic [PERF_W-1:0] r_perf_stall;

    // Accepted-beat and source-stall counters, cleared by each new pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_beats <= '0;
            r_perf_stall <= '0;
        end else if (w_start_acc) begin
            r_perf_beats <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_beat_acc) begin
                r_perf_beats <= sat_inc(r_perf_beats);
            end
            if (w_ready && !src_valid_i) begin
                r_perf_stall <= sat_inc(r_perf_stall);
            end
        end
    end

    assign perf_beats_o = r_perf_beats;
    assign perf_stall_o = r_perf_stall;
`endif

    assign src_ready_o       = w_ready;
    assign wire_connection_o = r_wire;
    assign v_bus_data_o      = r_v;
    assign h_bus_data_o      = r_h;
    assign top_data_o        = r_top;
    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl. Each pass is expanded into a per-cycle stimulus
// list and a per-cycle expected output timeline built from the pass rules
// (start, optional load cycle, beats with stalls, drain, done), then played
// against the DUT. Outputs are sampled on the falling clock edge.
module tb_pe_seq_ctrl;

    localparam int WD = 16;
    localparam int WL = 8;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [WL-1:0] len_i = '0;
    logic [WD-1:0] weight_i = '0;
    logic          src_valid_i = 1'b0;
    logic          src_ready_o;
    logic [WD-1:0] src_v_i = '0;
    logic [WD-1:0] src_h_i = '0;
    logic [WD-1:0] src_top_i = '0;
    logic [1:0]    wire_connection_o;
    logic [WD-1:0] v_bus_data_o;
    logic [WD-1:0] h_bus_data_o;
    logic [WD-1:0] top_data_o;
    logic          busy_o;
    logic          done_o;
    logic [2:0]    dbg_state_o;
`ifdef PE_SEQ_PERF_EN
    logic [31:0]   perf_beats_o;
    logic [31:0]   perf_stall_o;
`endif

    pe_seq_ctrl #(.WIDTH_DATA(WD), .WIDTH_LEN(WL), .DRAIN_CYC(DC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .mode_i            (mode_i),
        .len_i             (len_i),
        .weight_i          (weight_i),
        .src_valid_i       (src_valid_i),
        .src_ready_o       (src_ready_o),
        .src_v_i           (src_v_i),
        .src_h_i           (src_h_i),
        .src_top_i         (src_top_i),
        .wire_connection_o (wire_connection_o),
        .v_bus_data_o      (v_bus_data_o),
        .h_bus_data_o      (h_bus_data_o),
        .top_data_o        (top_data_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .dbg_state_o       (dbg_state_o)
`ifdef PE_SEQ_PERF_EN
        ,
        .perf_beats_o      (perf_beats_o),
        .perf_stall_o      (perf_stall_o)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [1:0]    wire_c;
        logic [WD-1:0] v;
        logic [WD-1:0] h;
        logic [WD-1:0] top;
        logic          busy;
        logic          done;
        logic          ready;
    } exp_t;

    typedef struct packed {
        logic          start;
        logic          mode;
        logic [WL-1:0] len;
        logic [WD-1:0] weight;
        logic          valid;
        logic [WD-1:0] v;
        logic [WD-1:0] h;
        logic [WD-1:0] top;
    } stim_t;

    exp_t  exp_q[$];
    stim_t stim_q[$];
    int    g_stalls[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    g_pass = 0;
    // bus values the DUT should be holding between passes
    logic [WD-1:0] m_v = '0;
    logic [WD-1:0] m_h = '0;
    logic [WD-1:0] m_top = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s pass=%0d t=%0t got=%0h expected=%0h", tag, g_pass, $time, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [1:0] w, input logic [WD-1:0] v,
                                    input logic [WD-1:0] h, input logic [WD-1:0] t,
                                    input logic b, input logic d, input logic r);
        exp_t e;
        e.wire_c = w; e.v = v; e.h = h; e.top = t;
        e.busy = b; e.done = d; e.ready = r;
        return e;
    endfunction

    // Idle stimulus with random junk on data; optional stray start pulse
    function automatic stim_t idle_stim(input int restart_pct);
        stim_t s;
        s.start  = ($urandom_range(99) < restart_pct);
        s.mode   = 1'($urandom_range(1));
        s.len    = WL'($urandom_range(255));
        s.weight = WD'($urandom);
        s.valid  = 1'b0;
        s.v      = WD'($urandom);
        s.h      = WD'($urandom);
        s.top    = WD'($urandom);
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input stim_t s);
        start_i     = s.start;
        mode_i      = s.mode;
        len_i       = s.len;
        weight_i    = s.weight;
        src_valid_i = s.valid;
        src_v_i     = s.v;
        src_h_i     = s.h;
        src_top_i   = s.top;
    endtask

    task automatic compare(input exp_t e);
        check_eq("wire",  32'(wire_connection_o), 32'(e.wire_c));
        check_eq("v_bus", 32'(v_bus_data_o),      32'(e.v));
        check_eq("h_bus", 32'(h_bus_data_o),      32'(e.h));
        check_eq("top",   32'(top_data_o),        32'(e.top));
        check_eq("busy",  32'(busy_o),            32'(e.busy));
        check_eq("done",  32'(done_o),            32'(e.done));
        check_eq("ready", 32'(src_ready_o),       32'(e.ready));
    endtask

    // Build the timeline for one pass and play it. pat=1 gives v=h=k, top=2k
    // for beat k. abort_at>=0 stops before checking that cycle.
    task automatic run_pass(input bit mode, input int len, input logic [WD-1:0] weight,
                            input int pat, input int stall_pct, input int restart_pct,
                            input int abort_at);
        logic [1:0]    cw;
        logic [WD-1:0] cv, ch, ct;
        stim_t         s;
        int            n_stall_tot;
        int            ns;
        g_pass++;
        exp_q.delete();
        stim_q.delete();
        cw = 2'd3; cv = m_v; ch = m_h; ct = m_top;
        n_stall_tot = 0;
        // start cycle: outputs still show the idle state
        s = idle_stim(0);
        s.start = 1'b1; s.mode = mode; s.len = WL'(len); s.weight = weight;
        stim_q.push_back(s);
        exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b0, 1'b0, 1'b0));
        if (len != 0) begin
            if (mode) begin
                stim_q.push_back(idle_stim(restart_pct));
                exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b1, 1'b0, 1'b0));
                cw = 2'd1; ch = weight;
            end
            for (int k = 1; k <= len; k++) begin
                if (g_stalls.size() == len) begin
                    ns = g_stalls[k-1];
                end else begin
                    ns = ($urandom_range(99) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
                end
                n_stall_tot += ns;
                for (int j = 0; j < ns; j++) begin
                    stim_q.push_back(idle_stim(restart_pct));
                    exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b1, 1'b0, 1'b1));
                    cw = 2'd3;
                end
                s = idle_stim(restart_pct);
                s.valid = 1'b1;
                if (pat == 1) begin
                    s.v = WD'(k); s.h = WD'(k); s.top = WD'(2 * k);
                end
                stim_q.push_back(s);
                exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b1, 1'b0, 1'b1));
                if (mode) begin
                    cw = 2'd2; ch = s.h; ct = s.top;
                end else begin
                    cw = 2'd0; cv = s.v; ch = s.h;
                end
            end
            // drain: stray valid beats must be ignored
            for (int d = 0; d < DC; d++) begin
                s = idle_stim(restart_pct);
                s.valid = 1'($urandom_range(1));
                stim_q.push_back(s);
                exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b1, 1'b0, 1'b0));
                cw = 2'd3; ct = '0;
            end
        end
        // cycle before the done pulse, the done pulse, then idle again
        stim_q.push_back(idle_stim(restart_pct));
        exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b1, 1'b0, 1'b0));
        stim_q.push_back(idle_stim(restart_pct));
        exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b1, 1'b1, 1'b0));
        stim_q.push_back(idle_stim(0));
        exp_q.push_back(mk_exp(cw, cv, ch, ct, 1'b0, 1'b0, 1'b0));

        for (int c = 0; c < stim_q.size(); c++) begin
            @(negedge clk);
            if (c == abort_at) return;
            compare(exp_q[c]);
            drive(stim_q[c]);
        end
        m_v = cv; m_h = ch; m_top = ct;
`ifdef PE_SEQ_PERF_EN
        check_eq("perf_beats", perf_beats_o, 32'(len));
        check_eq("perf_stall", perf_stall_o, 32'(n_stall_tot));
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        drive(idle_stim(0));
        repeat (2) @(negedge clk);
        compare(mk_exp(2'd3, '0, '0, '0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        compare(mk_exp(2'd3, '0, '0, '0, 1'b0, 1'b0, 1'b0));

        // MAC len=16, v=h=i, no stalls
        run_pass(1'b0, 16, '0, 1, 0, 0, -1);
        // chain len=15, weight=20, h=i, top=2i
        run_pass(1'b1, 15, 16'd20, 1, 0, 0, -1);
        // MAC len=4 with two 2-cycle stalls before beats 2 and 3
        g_stalls = '{0, 2, 2, 0};
        run_pass(1'b0, 4, '0, 1, 0, 0, -1);
        g_stalls.delete();
        // zero-length passes in both modes
        run_pass(1'b0, 0, '0, 0, 0, 0, -1);
        run_pass(1'b1, 0, 16'h1234, 0, 0, 0, -1);
        // heavy start re-pulsing during a pass
        run_pass(1'b0, 10, '0, 0, 20, 50, -1);
        run_pass(1'b1, 10, 16'hbeef, 0, 20, 50, -1);

        // async reset in the middle of a chain pass
        run_pass(1'b1, 15, 16'd20, 1, 0, 0, 8);
        drive(idle_stim(0));
        #2 rst_n = 1'b0;
        #1 compare(mk_exp(2'd3, '0, '0, '0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        m_v = '0; m_h = '0; m_top = '0;
        for (int i = 0; i < DC + 4; i++) begin
            @(negedge clk);
            compare(mk_exp(2'd3, '0, '0, '0, 1'b0, 1'b0, 1'b0));
        end
        run_pass(1'b1, 6, 16'h00a5, 1, 0, 0, -1);

        // randomized passes
        for (int p = 0; p < 24; p++) begin
            run_pass(1'($urandom_range(1)), int'($urandom_range(40, 1)), WD'($urandom),
                     0, 30, 10, -1);
        end
        // longest pass: beat count must not wrap early
        run_pass(1'b0, 255, '0, 0, 5, 0, -1);
        run_pass(1'b1, 255, 16'h7777, 0, 5, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
